// File: rtl/mux_arbiter.sv
// Round-robin arbiter feeding a 32-bit 2:1 mux from two valid/ready requesters.
// Grants are held for bursts of up to MAX_BURST words; the muxed word is registered in a one-entry output stage.
module mux_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validA,
    input  logic [WIDTH-1:0] dataA,
    output logic             readyA,
    input  logic             validB,
    input  logic [WIDTH-1:0] dataB,
    output logic             readyB,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    input  logic             outReady,
    output logic             select
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic               last_sel_r;

    logic               can_load_s;
    logic               xfer_a_s;
    logic               xfer_b_s;
    logic               burst_last_s;

    // The team 2:1 mux: 0 picks A, 1 picks B.
    function automatic logic [WIDTH-1:0] mux2(
        input logic             sel,
        input logic [WIDTH-1:0] in_a,
        input logic [WIDTH-1:0] in_b
    );
        logic [WIDTH-1:0] res;
        if (sel) begin
            res = in_b;
        end else begin
            res = in_a;
        end
        return res;
    endfunction

    // Handshake decode: a requester is accepted only while granted and the output stage can take a word.
    always_comb begin
        can_load_s   = !outValid || outReady;
        readyA       = (state_r == GRANT_A) && can_load_s;
        readyB       = (state_r == GRANT_B) && can_load_s;
        xfer_a_s     = validA && readyA;
        xfer_b_s     = validB && readyB;
        burst_last_s = (burst_cnt_r == LAST_CNT);
    end

    // Grant FSM with registered select, burst counter and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            select      <= 1'b0;
            burst_cnt_r <= CNT_ZERO;
            last_sel_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    burst_cnt_r <= CNT_ZERO;
                    if (validA && validB) begin
                        // Tie goes to whichever side was not served last.
                        if (last_sel_r) begin
                            state_r <= GRANT_A;
                            select  <= 1'b0;
                        end else begin
                            state_r <= GRANT_B;
                            select  <= 1'b1;
                        end
                    end else if (validA) begin
                        state_r <= GRANT_A;
                        select  <= 1'b0;
                    end else if (validB) begin
                        state_r <= GRANT_B;
                        select  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_A: begin
                    if (!validA) begin
                        last_sel_r  <= 1'b0;
                        burst_cnt_r <= CNT_ZERO;
                        if (validB) begin
                            state_r <= GRANT_B;
                            select  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (xfer_a_s && burst_last_s) begin
                        last_sel_r  <= 1'b0;
                        burst_cnt_r <= CNT_ZERO;
                        if (validB) begin
                            state_r <= GRANT_B;
                            select  <= 1'b1;
                        end else begin
                            state_r <= GRANT_A;
                        end
                    end else if (xfer_a_s) begin
                        burst_cnt_r <= burst_cnt_r + CNT_ONE;
                    end else begin
                        state_r <= GRANT_A;
                    end
                end
                GRANT_B: begin
                    if (!validB) begin
                        last_sel_r  <= 1'b1;
                        burst_cnt_r <= CNT_ZERO;
                        if (validA) begin
                            state_r <= GRANT_A;
                            select  <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (xfer_b_s && burst_last_s) begin
                        last_sel_r  <= 1'b1;
                        burst_cnt_r <= CNT_ZERO;
                        if (validA) begin
                            state_r <= GRANT_A;
                            select  <= 1'b0;
                        end else begin
                            state_r <= GRANT_B;
                        end
                    end else if (xfer_b_s) begin
                        burst_cnt_r <= burst_cnt_r + CNT_ONE;
                    end else begin
                        state_r <= GRANT_B;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    burst_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // One-entry output stage: load and consume may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outData  <= {WIDTH{1'b0}};
        end else if (xfer_a_s || xfer_b_s) begin
            outValid <= 1'b1;
            outData  <= mux2(select, dataA, dataB);
        end else if (outReady) begin
            outValid <= 1'b0;
        end else begin
            outValid <= outValid;
        end
    end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's 32-bit 2:1 mux (inputA/inputB/select → outMux).
- Shares one downstream path between two valid/ready requesters, A and B.
- Drives the mux select from an internal grant FSM and registers the muxed word into a one-entry output stage.
- Grants are held for bursts of up to MAX_BURST transfers so back-to-back words from one source stay contiguous.

Parameters:
WIDTH, 32, data width of both inputs and the output.
MAX_BURST, 4, maximum consecutive transfers per grant (≥1); counter width = clog2(MAX_BURST)+1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
validA  input  1  requester A has a word.
dataA  input  WIDTH  requester A word; held stable while validA=1 and readyA=0.
readyA  output  1  A's word is accepted this cycle.
validB  input  1  requester B has a word.
dataB  input  WIDTH  requester B word; same stability rule as A.
readyB  output  1  B's word is accepted this cycle.
outValid  output  1  outData holds a word.
outData  output  WIDTH  registered mux output.
outReady  input  1  consumer accepts outData.
select  output  1  current mux select: 0 = A, 1 = B; registered.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, outValid=0, outData=0, select=0, burstCnt=0, lastSel=1 (A wins the first tie).
  - readyA/readyB=0 combinationally.
  - Reset mid-operation discards any held word; no partial transfer may complete.
- canLoad = !outValid || outReady. A consume and a new load are allowed in the same cycle.
- readyA = (state==GRANT_A) && canLoad; readyB = (state==GRANT_B) && canLoad. Both are 0 in IDLE; they are never 1 together.
- Transfer X occurs when validX && readyX:
  - outData <= dataX (selected through select), outValid <= 1, burstCnt++.
- outValid clears when outReady && outValid and no transfer occurs in that cycle.
- FSM states: IDLE, GRANT_A, GRANT_B.
  - IDLE:
    - only A valid → GRANT_A; only B valid → GRANT_B.
    - both valid → grant the one ≠ lastSel.
    - none valid → stay.
    - select <= granted side; burstCnt <= 0.
  - GRANT_X, burst end (transfer with burstCnt == MAX_BURST-1):
    - lastSel <= X, burstCnt <= 0.
    - other side valid → GRANT_other; else validX → GRANT_X (new burst); else IDLE.
  - GRANT_X, validX=0 in a cycle (requester idle):
    - lastSel <= X, burstCnt <= 0.
    - other side valid → GRANT_other; else IDLE.
  - GRANT_X, otherwise (transfer not at burst end, or stalled by !canLoad): stay in GRANT_X.
  - A stall never ends a grant early.
- select updates only on the state transition edge. It always equals the granted side in GRANT states and holds its last value in IDLE.
- Latency:
  - From IDLE: validX rise → grant at next edge → accepted that cycle if canLoad → outValid one edge later (2 cycles).
  - Within a burst: 1 word per cycle when outReady is held 1.
- Fairness: with both sides continuously valid and outReady=1, the pattern is exactly MAX_BURST A words, then MAX_BURST B words, repeating; no idle cycle at switch-over.
- MAX_BURST=1: grant alternates every transfer when both sides are valid.

Test Plan:
- Reset/idle: rst_n=0 then 1, validA=validB=0 for 5 cycles → outValid=0, outData=0, select=0, readyA=readyB=0 throughout.
- Single A word: validA=1, dataA=14, outReady=1 → readyA=1 on cycle 1 after grant, outData=14 and outValid=1 on cycle 2, select=0.
- Tie and round-robin: both valid from reset, dataA=23, dataB=27, outReady=1, MAX_BURST=4 → 4×23, then 4×27, then 4×23; select toggles 0→1→0 at burst boundaries with no gap.
- Backpressure: B granted, outReady=0 for 3 cycles with outValid=1 → readyB=0, outData stable, grant kept. outReady=1 → next word is loaded in the same cycle the current one is consumed.
- Requester drop: A granted, validA falls after 2 words while validB=1 → next cycle GRANT_B, select=1; burstCnt restarts at 0.
- Async reset mid-burst: assert rst_n=0 between clock edges during a B burst → outValid, select and both readys clear immediately. After release, A wins the first tie.
